// File: rtl/img_proc_pkg.sv
// Shared helpers for the pixel datapath: constant-function utilities and
// the rounding-addend rule used by the pipelined multipliers.
package img_proc_pkg;

  // Number of bits needed to index n items (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // Integer ceiling division; yields 0 for a non-positive divisor so that
  // elaboration reaches the parameter checks instead of dividing by zero.
  function automatic int ceil_div(input int n, input int d);
    return (d < 1) ? 0 : (n + d - 1) / d;
  endfunction

  // Half-LSB addend applied before a right shift when rounding is enabled.
  function automatic logic [63:0] round_addend(input int shift, input bit round_en);
    if (round_en && shift > 0) begin
      return 64'd1 << (shift - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/mult_pipe_uu_if.sv
// Operand/result stream bundle for mult_pipe_uu: valid/ready on both
// sides plus a sideband tag that travels with each product.
interface mult_pipe_uu_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 9,
  parameter int SHIFT = 0,
  parameter int TAG_W = 1
);
  localparam int P_W = A_W + B_W - SHIFT;

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [P_W-1:0]   p;
  logic [TAG_W-1:0] out_tag;

  // Source of operands and sink of results.
  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, p, out_tag
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, p, out_tag
  );
endinterface

// File: rtl/mult_pp_stage.sv
// One pipeline rank: adds N_ROWS partial products (a << (OFF+j) for each set
// bit j of the remaining multiplier bits) to the running accumulator and
// registers the result together with the operands and tag.
module mult_pp_stage #(
  parameter int A_W    = 16,
  parameter int B_W    = 9,
  parameter int TAG_W  = 1,
  parameter int N_ROWS = 3,
  parameter int OFF    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 in_valid,
  input  logic [A_W+B_W-1:0]   in_acc,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  output logic [A_W+B_W-1:0]   out_acc,
  output logic [A_W-1:0]       out_a,
  output logic [B_W-1:0]       out_b,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int ACC_W = A_W + B_W;

  logic [ACC_W-1:0] sum;

  // Partial-product adder for this rank's slice of the multiplier.
  always_comb begin
    // NOTE: the default is assigned first so every path writes sum (no latch),
    // and blocking '=' lets each row build on the previous one.
    sum = in_acc;
    for (int j = 0; j < N_ROWS; j++) begin
      if (in_b[j]) begin
        sum = sum + (ACC_W'(in_a) << (OFF + j));
      end
    end
  end

  // Rank register: loads when the whole pipe advances, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are reset too so the outputs are deterministic
    // after reset, even though only the valid flag is functionally required.
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      // NOTE: non-blocking '<=' so all ranks sample their inputs at the same
      // edge and the data moves exactly one rank per advance.
      out_valid <= in_valid;
      out_acc   <= sum;
      out_a     <= in_a;
      out_b     <= in_b >> N_ROWS;
      out_tag   <= in_tag;
    end
  end

endmodule

// File: rtl/mult_pipe_uu.sv
// Pipelined unsigned A x B multiplier with valid/ready flow control, optional
// rounded right shift and a pass-through tag. A global stall freezes every
// rank at once; bubbles travel with the data and are not squeezed out.
module mult_pipe_uu
  import img_proc_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 9,
  parameter int ROWS  = 3,
  parameter int SHIFT = 0,
  parameter int ROUND = 0,
  parameter int TAG_W = 1
) (
  input logic          clk,
  input logic          rst,
  mult_pipe_uu_if.slave bus
);
  localparam int STAGES = ceil_div(B_W, ROWS);
  localparam int ACC_W  = A_W + B_W;
  localparam logic [ACC_W-1:0] RND = ACC_W'(round_addend(SHIFT, ROUND != 0));

  if (SHIFT > A_W) begin : g_err_shift
    $error("mult_pipe_uu: SHIFT (%0d) must not exceed A_W (%0d)", SHIFT, A_W);
  end
  if (ROWS < 1) begin : g_err_rows
    $error("mult_pipe_uu: ROWS must be at least 1");
  end
  if (TAG_W < 1) begin : g_err_tag
    $error("mult_pipe_uu: TAG_W must be at least 1");
  end

  // Rank 0 only captures the operands (acc = rounding addend); ranks
  // 1..STAGES each add one group of ROWS partial products. A result is thus
  // visible STAGES advancing edges after the edge that accepted it.
  logic             v_q   [STAGES+1];
  logic [ACC_W-1:0] acc_q [STAGES+1];
  logic [A_W-1:0]   a_q   [STAGES+1];
  logic [B_W-1:0]   b_q   [STAGES+1];
  logic [TAG_W-1:0] tag_q [STAGES+1];
  logic             adv;

  // The pipe moves whenever the output slot is empty or being drained.
  assign adv          = !v_q[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k <= STAGES; k++) begin : g_rank
    if (k == 0) begin : g_load
      mult_pp_stage #(
        .A_W(A_W), .B_W(B_W), .TAG_W(TAG_W), .N_ROWS(0), .OFF(0)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .in_valid (bus.in_valid),
        .in_acc   (RND),
        .in_a     (bus.a),
        .in_b     (bus.b),
        .in_tag   (bus.in_tag),
        .out_valid(v_q[k]),
        .out_acc  (acc_q[k]),
        .out_a    (a_q[k]),
        .out_b    (b_q[k]),
        .out_tag  (tag_q[k])
      );
    end else begin : g_add
      // The last rank takes whatever rows remain when B_W is not a multiple of ROWS.
      localparam int OFF = (k - 1) * ROWS;
      localparam int NR  = (B_W - OFF < ROWS) ? (B_W - OFF) : ROWS;
      mult_pp_stage #(
        .A_W(A_W), .B_W(B_W), .TAG_W(TAG_W), .N_ROWS(NR), .OFF(OFF)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .in_valid (v_q[k-1]),
        .in_acc   (acc_q[k-1]),
        .in_a     (a_q[k-1]),
        .in_b     (b_q[k-1]),
        .in_tag   (tag_q[k-1]),
        .out_valid(v_q[k]),
        .out_acc  (acc_q[k]),
        .out_a    (a_q[k]),
        .out_b    (b_q[k]),
        .out_tag  (tag_q[k])
      );
    end
  end

  assign bus.out_valid = v_q[STAGES];
  assign bus.p         = acc_q[STAGES][ACC_W-1:SHIFT];
  assign bus.out_tag   = tag_q[STAGES];

  // The last rank's operand copies and the shifted-off LSBs have no consumer.
  logic unused_tail;
  assign unused_tail = ^{acc_q[STAGES], a_q[STAGES], b_q[STAGES]};

endmodule

// File: tb/tb_mult_pipe_uu.sv
// Bench for mult_pipe_uu. Four instances run side by side on one stimulus:
//   u0 defaults, u1 SHIFT=8 ROUND=1, u2 SHIFT=8 ROUND=0, u3 A_W=12 B_W=10 ROWS=4 TAG_W=4.
// A queue model (product arithmetic plus "visible after STAGES advances")
// is compared against every instance on every falling edge.
module tb_mult_pipe_uu;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a   = '0;
  logic [8:0]  b   = '0;
  logic [11:0] a3  = '0;
  logic [9:0]  b3  = '0;
  logic [3:0]  tag = '0;
  bit          bp_mode = 1'b0;
  logic [39:0] rdy_pat = 40'b1011_0000_0110_1101_1100_1010_0111_1011_0101_1101;

  int n_vec  = 0;
  int n_fail = 0;

  mult_pipe_uu_if #(.A_W(16), .B_W(9),  .SHIFT(0), .TAG_W(1)) if0 ();
  mult_pipe_uu_if #(.A_W(16), .B_W(9),  .SHIFT(8), .TAG_W(1)) if1 ();
  mult_pipe_uu_if #(.A_W(16), .B_W(9),  .SHIFT(8), .TAG_W(1)) if2 ();
  mult_pipe_uu_if #(.A_W(12), .B_W(10), .SHIFT(0), .TAG_W(4)) if3 ();

  assign if0.in_valid = in_valid; assign if0.a = a;  assign if0.b = b;  assign if0.in_tag = tag[0]; assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid; assign if1.a = a;  assign if1.b = b;  assign if1.in_tag = tag[0]; assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid; assign if2.a = a;  assign if2.b = b;  assign if2.in_tag = tag[0]; assign if2.out_ready = out_ready;
  assign if3.in_valid = in_valid; assign if3.a = a3; assign if3.b = b3; assign if3.in_tag = tag;    assign if3.out_ready = out_ready;

  mult_pipe_uu #(.A_W(16), .B_W(9), .ROWS(3), .SHIFT(0), .ROUND(0), .TAG_W(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mult_pipe_uu #(.A_W(16), .B_W(9), .ROWS(3), .SHIFT(8), .ROUND(1), .TAG_W(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  mult_pipe_uu #(.A_W(16), .B_W(9), .ROWS(3), .SHIFT(8), .ROUND(0), .TAG_W(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  mult_pipe_uu #(.A_W(12), .B_W(10), .ROWS(4), .SHIFT(0), .ROUND(0), .TAG_W(4)) u3 (.clk(clk), .rst(rst), .bus(if3));

  logic        ov [4];
  logic        ir [4];
  logic [31:0] pw [4];
  logic [3:0]  tw [4];
  assign ov[0] = if0.out_valid; assign ir[0] = if0.in_ready; assign pw[0] = 32'(if0.p); assign tw[0] = 4'(if0.out_tag);
  assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready; assign pw[1] = 32'(if1.p); assign tw[1] = 4'(if1.out_tag);
  assign ov[2] = if2.out_valid; assign ir[2] = if2.in_ready; assign pw[2] = 32'(if2.p); assign tw[2] = 4'(if2.out_tag);
  assign ov[3] = if3.out_valid; assign ir[3] = if3.in_ready; assign pw[3] = 32'(if3.p); assign tw[3] = 4'(if3.out_tag);

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint p;
    longint lit;
    int     tag;
    longint acc;
  } ent_t;

  ent_t   fifo [4][64];
  int     wr [4];
  int     rd [4];
  longint adv_cnt [4];
  longint cur_lit [4];

  function automatic longint model_p(int d, longint av, longint bv);
    int     sh;
    longint prod;
    sh   = (d == 1 || d == 2) ? 8 : 0;
    prod = av * bv;
    if (d == 1) prod = prod + (longint'(1) << (sh - 1));
    return prod >> sh;
  endfunction

  function automatic bit exp_valid(int d);
    return (wr[d] != rd[d]) && (adv_cnt[d] - fifo[d][rd[d] & 63].acc == LAT);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int d = 0; d < 4; d++) s += wr[d] - rd[d];
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit   ev;
    ent_t ent;
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        wr[d]      <= 0;
        rd[d]      <= 0;
        adv_cnt[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        ev = exp_valid(d);
        if (!ev || out_ready) begin
          if (ev) rd[d] <= rd[d] + 1;
          adv_cnt[d] <= adv_cnt[d] + 1;
          if (in_valid) begin
            ent.p   = (d == 3) ? model_p(d, longint'(a3), longint'(b3)) : model_p(d, longint'(a), longint'(b));
            ent.lit = cur_lit[d];
            ent.tag = (d == 3) ? int'(tag) : int'(tag[0]);
            ent.acc = adv_cnt[d] + 1;
            fifo[d][wr[d] & 63] <= ent;
            wr[d] <= wr[d] + 1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit ev;
    for (int d = 0; d < 4; d++) begin
      ev = exp_valid(d);
      check($sformatf("u%0d out_valid", d), longint'(ov[d]), longint'(ev));
      check($sformatf("u%0d in_ready", d), longint'(ir[d]), longint'(!ev || out_ready));
      if (ev) begin
        check($sformatf("u%0d p", d), longint'(pw[d]), fifo[d][rd[d] & 63].p);
        check($sformatf("u%0d out_tag", d), longint'(tw[d]), longint'(fifo[d][rd[d] & 63].tag));
        if (fifo[d][rd[d] & 63].lit >= 0)
          check($sformatf("u%0d p literal", d), longint'(pw[d]), fifo[d][rd[d] & 63].lit);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [15:0] a;
    logic [8:0]  b;
    logic [11:0] a3;
    logic [9:0]  b3;
    logic [3:0]  tag;
    longint      l0, l1, l2, l3;
  } vec_t;

  function automatic vec_t mk(logic [15:0] va, logic [8:0] vb, logic [11:0] va3, logic [9:0] vb3,
                              logic [3:0] vt, longint l0, longint l1, longint l2, longint l3);
    vec_t v;
    v.a = va; v.b = vb; v.a3 = va3; v.b3 = vb3; v.tag = vt;
    v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    return mk(16'($urandom), 9'($urandom), 12'($urandom), 10'($urandom), 4'($urandom), -1, -1, -1, -1);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    bit acc = 1'b0;
    int tmo = 0;
    a = v.a; b = v.b; a3 = v.a3; b3 = v.b3; tag = v.tag;
    cur_lit[0] = v.l0; cur_lit[1] = v.l1; cur_lit[2] = v.l2; cur_lit[3] = v.l3;
    in_valid = 1'b1;
    while (!acc && tmo < 200) begin
      @(posedge clk);
      acc = if0.in_ready;
      tmo++;
    end
    #1;
    in_valid = 1'b0;
    check("operand accepted", longint'(acc), 1);
  endtask

  task automatic lat_check(input vec_t v);
    check("latency u0 edge+0", longint'(ov[0]), 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("latency u0 early", longint'(ov[0]), 0);
      check("latency u3 early", longint'(ov[3]), 0);
    end
    @(posedge clk); #1;
    check("latency u0 valid", longint'(ov[0]), 1);
    check("latency u0 p", longint'(pw[0]), v.l0);
    check("latency u0 tag", longint'(tw[0]), longint'(v.tag[0]));
    check("latency u3 valid", longint'(ov[3]), 1);
    check("latency u3 p", longint'(pw[3]), v.l3);
  endtask

  task automatic drain();
    int n = 0;
    while (n < 200 && pending() != 0) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain pending", longint'(pending()), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        out_ready = rdy_pat[39];
        rdy_pat   = {rdy_pat[38:0], rdy_pat[39]};
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    vec_t v;
    vt[0] = mk(16'hFFFF, 9'h1FF, 12'hFFF, 10'h3FF, 4'hA, 64'h1FEFE01, 64'h1FEFE, 64'h1FEFE, 64'h3FEC01);
    vt[1] = mk(16'h0001, 9'h080, 12'h001, 10'h200, 4'h5, 128, 1, 0, 512);
    vt[2] = mk(16'h00FF, 9'h081, 12'hABC, 10'h001, 4'h3, 32895, 128, 128, 64'hABC);
    vt[3] = mk(16'h0000, 9'h1FF, 12'h000, 10'h3FF, 4'h0, 0, 0, 0, 0);
    vt[4] = mk(16'hBEEF, 9'h001, 12'hFFF, 10'h000, 4'hF, 64'hBEEF, 64'hBF, 64'hBE, 0);
    vt[5] = mk(16'h1234, 9'h000, 12'h123, 10'h155, 4'h6, 0, 0, 0, -1);
    vt[0].tag = 4'hB;

    // reset state
    #2;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset u%0d out_valid", d), longint'(ov[d]), 0);
      check($sformatf("reset u%0d p", d), longint'(pw[d]), 0);
      check($sformatf("reset u%0d out_tag", d), longint'(tw[d]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) check($sformatf("u%0d in_ready after reset", d), longint'(ir[d]), 1);

    // single transaction, latency pinned to literal values
    send(vt[0]);
    lat_check(vt[0]);

    // directed corners back to back, then a random stream
    for (int i = 1; i < 6; i++) send(vt[i]);
    for (int i = 0; i < 100; i++) send(rnd_vec());
    drain();

    // backpressure with a fixed ready pattern (includes five low cycles)
    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) send(rnd_vec());
    drain();
    bp_mode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // asynchronous reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      v = rnd_vec();
      send(v);
    end
    @(posedge clk); #1;
    check("in flight u0 out_valid", longint'(ov[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("async reset u%0d out_valid", d), longint'(ov[d]), 0);
      check($sformatf("async reset u%0d p", d), longint'(pw[d]), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(vt[0]);
    lat_check(vt[0]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
